// File: rtl/cache_arbiter_if.sv
// Bundle of the L1 miss ports, the shared lower-level port and the perf-counter pulses.
// The arbiter uses the slave view; caches, memory and counters use the master view.
interface cache_arbiter_if #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
);
    // I-cache miss port
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_read;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    // D-cache miss / writeback port
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_read;
    logic                  d_write;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    // Shared lower-level port
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    // Performance-counter pulses
    logic                  arb_conflict;
    logic                  arb_wait;

    modport slave (
        input  i_addr, i_read,
        input  d_addr, d_read, d_write, d_wdata,
        input  mem_rdata, mem_resp,
        output i_rdata, i_resp,
        output d_rdata, d_resp,
        output mem_addr, mem_read, mem_write, mem_wdata,
        output arb_conflict, arb_wait
    );

    modport master (
        output i_addr, i_read,
        output d_addr, d_read, d_write, d_wdata,
        output mem_rdata, mem_resp,
        input  i_rdata, i_resp,
        input  d_rdata, d_resp,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        input  arb_conflict, arb_wait
    );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the I-cache and
// D-cache; each grant latches address, op and writeback data for the whole transaction.
module cache_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    cache_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  arb_conflict_q, arb_conflict_d;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic serving_i;
    logic serving_d;

    always_comb begin
        i_req     = bus.i_read;
        d_req     = bus.d_read | bus.d_write;
        serving_i = (state_q == SERVE_I);
        serving_d = (state_q == SERVE_D);
    end

    // Grant decision only happens in IDLE; on a tie the side not served last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (i_req && d_req) begin
                grant_d = (last_grant_q == GRANT_I);
                grant_i = (last_grant_q == GRANT_D);
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        arb_conflict_d = 1'b0;

        case (state_q)
            IDLE: begin
                arb_conflict_d = i_req & d_req;
                if (grant_d) begin
                    state_d     = SERVE_D;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    // A simultaneous read+write request is treated as a writeback.
                    mem_write_d = bus.d_write;
                    mem_read_d  = ~bus.d_write;
                end else if (grant_i) begin
                    state_d     = SERVE_I;
                    mem_addr_d  = bus.i_addr;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                end
            end

            SERVE_I: begin
                if (bus.mem_resp) begin
                    state_d      = RECOVER;
                    last_grant_d = GRANT_I;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end

            SERVE_D: begin
                if (bus.mem_resp) begin
                    state_d      = RECOVER;
                    last_grant_d = GRANT_D;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end

            RECOVER: begin
                // Dead cycle so the requester just served can withdraw its request.
                state_d = IDLE;
            end

            default: begin
                state_d     = IDLE;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= GRANT_I;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            arb_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            arb_conflict_q <= arb_conflict_d;
        end
    end

    // Read data is a straight pass-through; consumers qualify it with their resp pulse.
    assign bus.i_rdata      = bus.mem_rdata;
    assign bus.d_rdata      = bus.mem_rdata;
    assign bus.i_resp       = serving_i & bus.mem_resp;
    assign bus.d_resp       = serving_d & bus.mem_resp;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.arb_conflict = arb_conflict_q;
    assign bus.arb_wait     = (i_req & ~serving_i) | (d_req & ~serving_d);

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever i_resp or d_resp fires.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

    cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit             is_d;
        bit             wr;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  wdata;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   conflicts   = 0;
    bit   resp_en     = 1'b1;
    int   lat         = 4;
    int   resp_cnt    = 0;

    function automatic logic [LW-1:0] line_pat(input logic [AW-1:0] a);
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++)
            r[k*32 +: 32] = (a ^ 32'hDEAD_0000) + 32'(k) * 32'h0101_0101;
        return r;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input bit is_d, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        return e;
    endfunction

    // Lower-level memory model: answers after lat cycles of mem_read/mem_write.
    initial begin
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resp_en) begin
                resp_cnt = 0;
            end else if (bus.mem_resp) begin
                bus.mem_resp = 1'b0;
                resp_cnt     = 0;
            end else if (bus.mem_read || bus.mem_write) begin
                resp_cnt++;
                if (resp_cnt == lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = line_pat(bus.mem_addr);
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Monitor: every response pops one expected transaction.
    always @(negedge clk) begin
        vectors++;
        if ((bus.mem_read && bus.mem_write) || (bus.i_resp && bus.d_resp)) begin
            miscompares++;
            $display("FAIL exclusivity: mem_read=%b mem_write=%b i_resp=%b d_resp=%b",
                     bus.mem_read, bus.mem_write, bus.i_resp, bus.d_resp);
        end
        if (bus.arb_conflict) conflicts++;
        if (bus.i_resp || bus.d_resp) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: i_resp=%b d_resp=%b, expected no response",
                         bus.i_resp, bus.d_resp);
            end else begin
                mon_e = sb.pop_front();
                check_bit("resp_is_d", bus.d_resp, mon_e.is_d);
                check_addr("resp_mem_addr", bus.mem_addr, mon_e.addr);
                check_bit("resp_mem_write", bus.mem_write, mon_e.wr);
                check_bit("resp_mem_read", bus.mem_read, !mon_e.wr);
                if (mon_e.wr) check_line("resp_mem_wdata", bus.mem_wdata, mon_e.wdata);
                check_line("resp_rdata", mon_e.is_d ? bus.d_rdata : bus.i_rdata, line_pat(mon_e.addr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input bit is_d, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = is_d ? bus.d_resp : bus.i_resp;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no resp within 60 cycles, expected one", name);
        end
    endtask

    task automatic run_i(input logic [AW-1:0] a);
        bus.i_addr = a;
        bus.i_read = 1'b1;
        wait_resp(1'b0, "run_i_timeout");
        cyc();
        bus.i_read = 1'b0;
    endtask

    task automatic run_d(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [LW-1:0] wd);
        bus.d_addr  = a;
        bus.d_wdata = wd;
        bus.d_read  = rd;
        bus.d_write = wr;
        wait_resp(1'b1, "run_d_timeout");
        cyc();
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    logic [LW-1:0] wd_a5;
    logic [LW-1:0] wd_5a;
    logic [LW-1:0] wd_3c;
    int            base;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        wd_a5 = {32{8'hA5}};
        wd_5a = {32{8'h5A}};
        wd_3c = {32{8'h3C}};
        bus.i_addr = '0; bus.i_read = 1'b0;
        bus.d_addr = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_bit("rst_mem_read", bus.mem_read, 1'b0);
        check_bit("rst_mem_write", bus.mem_write, 1'b0);
        check_addr("rst_mem_addr", bus.mem_addr, '0);
        check_line("rst_mem_wdata", bus.mem_wdata, '0);
        check_bit("rst_arb_conflict", bus.arb_conflict, 1'b0);
        check_bit("rst_arb_wait", bus.arb_wait, 1'b0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // I-only read, latency 4, request in cycle 0
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_1000, '0));
        bus.i_addr = 32'h0000_1000;
        bus.i_read = 1'b1;
        @(negedge clk);
        check_bit("t1_c0_mem_read", bus.mem_read, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check_bit("t1_mem_read", bus.mem_read, 1'b1);
            check_addr("t1_mem_addr", bus.mem_addr, 32'h0000_1000);
            check_bit("t1_i_resp", bus.i_resp, c == 4);
            check_bit("t1_d_resp", bus.d_resp, 1'b0);
        end
        cyc();
        bus.i_read = 1'b0;
        @(negedge clk);
        check_bit("t1_c5_mem_read", bus.mem_read, 1'b0);
        check_bit("t1_c5_i_resp", bus.i_resp, 1'b0);
        cyc();
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_1040, '0));
        bus.i_addr = 32'h0000_1040;
        bus.i_read = 1'b1;
        @(negedge clk);
        check_bit("t1_c6_mem_read", bus.mem_read, 1'b0);
        @(negedge clk);
        check_bit("t1_idle_at_c6_read", bus.mem_read, 1'b1);
        check_addr("t1_idle_at_c6_addr", bus.mem_addr, 32'h0000_1040);
        wait_resp(1'b0, "t1_second_timeout");
        cyc();
        bus.i_read = 1'b0;
        cyc();

        // D writeback with d_wdata changing mid-transaction
        sb.push_back(mk(1'b1, 1'b1, 32'h0000_2040, wd_a5));
        bus.d_addr  = 32'h0000_2040;
        bus.d_wdata = wd_a5;
        bus.d_write = 1'b1;
        cyc();
        cyc();
        bus.d_wdata = wd_5a;
        @(negedge clk);
        check_line("t2_mem_wdata_mid", bus.mem_wdata, wd_a5);
        check_bit("t2_mem_write_mid", bus.mem_write, 1'b1);
        wait_resp(1'b1, "t2_timeout");
        cyc();
        bus.d_write = 1'b0;
        cyc();

        // Tie right after reset: D first, one conflict pulse, then I
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        base = conflicts;
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, '0));
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_3100, '0));
        fork
            run_d(32'h0000_3000, 1'b1, 1'b0, '0);
            run_i(32'h0000_3100);
        join
        cyc();
        check_int("t3_conflict_pulses", conflicts - base, 1);

        // Continuous contention: strict alternation D,I,... over 8 rounds
        base = conflicts;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(1'b1, 1'b0, 32'h0000_4000 + 32'(k) * 32'h40, '0));
            sb.push_back(mk(1'b0, 1'b0, 32'h0000_5000 + 32'(k) * 32'h40, '0));
        end
        fork
            for (int k = 0; k < 4; k++) begin
                run_d(32'h0000_4000 + 32'(k) * 32'h40, 1'b1, 1'b0, '0);
                cyc();
            end
            for (int k = 0; k < 4; k++) begin
                run_i(32'h0000_5000 + 32'(k) * 32'h40);
                cyc();
            end
        join
        cyc();
        // Last I grant finds D idle, so only 7 of the 8 decisions are ties.
        check_int("t3_alt_conflicts", conflicts - base, 7);

        // d_read and d_write together: writeback only
        sb.push_back(mk(1'b1, 1'b1, 32'h0000_6000, wd_3c));
        bus.d_addr  = 32'h0000_6000;
        bus.d_wdata = wd_3c;
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_bit("t4_mem_read", bus.mem_read, 1'b0);
        check_bit("t4_mem_write", bus.mem_write, 1'b1);
        wait_resp(1'b1, "t4_timeout");
        cyc();
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        cyc();

        // Reset during SERVE_I with a late mem_resp
        resp_en = 1'b0;
        bus.i_addr = 32'h0000_7000;
        bus.i_read = 1'b1;
        cyc();
        cyc();
        rst_n      = 1'b0;
        bus.i_read = 1'b0;
        @(negedge clk);
        check_bit("t5_serving_before_rst", bus.mem_read, 1'b1);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("t5_mem_read_after_rst", bus.mem_read, 1'b0);
        cyc();
        bus.mem_rdata = line_pat(32'h0000_7000);
        bus.mem_resp  = 1'b1;
        @(negedge clk);
        check_bit("t5_late_i_resp", bus.i_resp, 1'b0);
        check_bit("t5_late_d_resp", bus.d_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        check_bit("t5_idle_mem_read", bus.mem_read, 1'b0);
        check_bit("t5_idle_mem_write", bus.mem_write, 1'b0);
        resp_en = 1'b1;
        cyc();
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_7040, '0));
        run_i(32'h0000_7040);
        cyc();

        // Stray mem_resp in IDLE
        resp_en = 1'b0;
        bus.mem_resp = 1'b1;
        @(negedge clk);
        check_bit("t6_stray_i_resp", bus.i_resp, 1'b0);
        check_bit("t6_stray_d_resp", bus.d_resp, 1'b0);
        cyc();
        bus.mem_resp = 1'b0;
        @(negedge clk);
        check_bit("t6_stray_mem_read", bus.mem_read, 1'b0);
        check_bit("t6_stray_mem_write", bus.mem_write, 1'b0);
        check_bit("t6_stray_conflict", bus.arb_conflict, 1'b0);
        resp_en = 1'b1;
        cyc();

        // arb_wait while I is pending behind a D transaction
        sb.push_back(mk(1'b1, 1'b0, 32'h0000_8000, '0));
        sb.push_back(mk(1'b0, 1'b0, 32'h0000_8100, '0));
        fork
            run_d(32'h0000_8000, 1'b1, 1'b0, '0);
            begin
                cyc();
                bus.i_addr = 32'h0000_8100;
                bus.i_read = 1'b1;
                for (int n = 0; n < 60; n++) begin
                    @(negedge clk);
                    if (bus.mem_read && bus.mem_addr == 32'h0000_8100) break;
                    check_bit("t6_arb_wait", bus.arb_wait, 1'b1);
                end
                wait_resp(1'b0, "t6_i_timeout");
                cyc();
                bus.i_read = 1'b0;
            end
        join
        cyc();
        @(negedge clk);
        check_bit("t6_arb_wait_idle", bus.arb_wait, 1'b0);
        check_int("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
